lfsr_burst_ctrl: RTL and testbench

Sequencer for the `lfsr` pseudo-random bit generator. On a start request it optionally reseeds the LFSR, steps it to collect `len` words of WORD_WIDTH bits each, and delivers each word over a valid/ready handshake. The LFSR is paused while a word waits for the consumer, so backpressure never changes the bit stream. The block sits between a test-pattern or scrambler consumer and a privately instantiated `lfsr`.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr.sv | 40 ++++
 rtl/lfsr_burst_ctrl.sv | 125 ++++++++++++
 tb/tb_lfsr_burst_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the lfsr generator and its burst sequencer.
package lfsr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FILL,
        OUT,
        DONE
    } burst_state_e;

    localparam int                      LFSR_WIDTH_DEF = 3;
    localparam logic [LFSR_WIDTH_DEF:0] POLYNOMIAL_DEF = 4'b0111;

endpackage

// File: rtl/lfsr.sv
// Fibonacci LFSR with XNOR feedback; the all-zero clear/reset state is a live state.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int               width      = LFSR_WIDTH_DEF,
    parameter logic [width:0]   polynomial = POLYNOMIAL_DEF
) (
    input  logic clk,
    input  logic res_n,
    input  logic enable,
    input  logic clear,
    output logic d_out
);

    logic [width-1:0] state_q;
    logic [width-1:0] state_d;
    logic             feedback;

    // polynomial[k] taps state bit k-1; polynomial[0] is the implicit constant term.
    always_comb begin
        feedback = ~^(state_q & polynomial[width:1]);
        state_d  = state_q;
        if (clear) begin
            state_d = '0;
        end else if (enable) begin
            state_d = {state_q[width-2:0], feedback};
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign d_out = state_q[width-1];

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer: collects LFSR bits into words and hands them out over valid/ready,
// pausing the LFSR while a word waits so backpressure never alters the bit stream.
module lfsr_burst_ctrl
    import lfsr_pkg::*;
#(
    parameter int                   LFSR_WIDTH = LFSR_WIDTH_DEF,
    parameter logic [LFSR_WIDTH:0]  POLYNOMIAL = POLYNOMIAL_DEF,
    parameter int                   WORD_WIDTH = 8,
    parameter int                   LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic                  reseed,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    output logic                  busy,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  done
);

    localparam int                   BIT_W    = $clog2(WORD_WIDTH);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(WORD_WIDTH - 1);
    localparam logic [BIT_W-1:0]     BIT_ONE  = BIT_W'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    burst_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic                  busy_q, valid_q, done_q;
    logic                  enable_q, clear_q;
    logic                  lfsr_bit;
    logic                  lfsr_res_n;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bitcnt_d = '0;
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        remaining_d = len;
                        state_d     = reseed ? CLEAR : FILL;
                    end
                end
            end
            CLEAR: state_d = FILL;
            FILL: begin
                shreg_d = {shreg_q[WORD_WIDTH-2:0], lfsr_bit};
                if (bitcnt_q == LAST_BIT) begin
                    bitcnt_d = '0;
                    state_d  = OUT;
                end else begin
                    bitcnt_d = bitcnt_q + BIT_ONE;
                end
            end
            OUT: begin
                if (word_ready) begin
                    remaining_d = remaining_q - LEN_ONE;
                    state_d     = (remaining_q == LEN_ONE) ? DONE : FILL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over start and over a pending handshake.
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Outputs and LFSR controls are decoded from the next state so they are registered.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            enable_q    <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            busy_q      <= (state_d != IDLE);
            valid_q     <= (state_d == OUT);
            done_q      <= (state_d == DONE);
            enable_q    <= (state_d == FILL);
            clear_q     <= (state_d == CLEAR);
        end
    end

    assign lfsr_res_n = ~res;

    lfsr #(
        .width      (LFSR_WIDTH),
        .polynomial (POLYNOMIAL)
    ) lfsr_I (
        .clk    (clk),
        .res_n  (lfsr_res_n),
        .enable (enable_q),
        .clear  (clear_q),
        .d_out  (lfsr_bit)
    );

    assign busy       = busy_q;
    assign word_valid = valid_q;
    assign word_out   = shreg_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Scoreboard bench for lfsr_burst_ctrl: a golden bit-stream model fills the expected-word
// queue at stimulus time and a negedge monitor checks every accepted word.
module tb_lfsr_burst_ctrl;

    localparam int              LW   = 3;
    localparam int              W    = 8;
    localparam int              LENW = 8;
    localparam logic [LW:0]     POLY = 4'b0111;

    logic            clk = 1'b0;
    logic            res, start, reseed, abort, word_ready;
    logic [LENW-1:0] len;
    logic            busy, word_valid, done;
    logic [W-1:0]    word_out;

    lfsr_burst_ctrl #(
        .LFSR_WIDTH (LW),
        .POLYNOMIAL (POLY),
        .WORD_WIDTH (W),
        .LEN_WIDTH  (LENW)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .reseed     (reseed),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    int unsigned  g_state;

    int v_cycs[$];
    int hs_cycs[$];
    int d_cycs[$];
    int busy0, busy1, busy_low;

    // Golden generator: returns the current MSB, then shifts in the XNOR of the tapped bits.
    function automatic bit g_bit();
        int unsigned taps;
        int unsigned fb;
        bit          b;
        taps    = int'(POLY) >> 1;
        b       = ((g_state >> (LW - 1)) & 1) != 0;
        fb      = ($countones(g_state & taps) % 2 == 0) ? 1 : 0;
        g_state = ((g_state << 1) | fb) & ((1 << LW) - 1);
        return b;
    endfunction

    function automatic logic [W-1:0] g_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) w[W-1-i] = g_bit();
        return w;
    endfunction

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(g_word());
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: word data, stability under backpressure, and LFSR pause while a word is offered.
    logic         pv = 1'b0, pr = 1'b0, pa = 1'b0;
    logic [W-1:0] pw = '0;
    always @(negedge clk) begin
        if (res) begin
            pv = 1'b0; pr = 1'b0; pa = 1'b0;
        end else begin
            if (pv && !pr && !pa) begin
                check("valid held", word_valid, 1);
                check("word stable", word_out, pw);
            end
            if (word_valid) begin
                check("lfsr paused while valid", dut.lfsr_I.enable, 0);
                if (word_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected word: got %0h, expected none", word_out);
                    end else begin
                        check("word", word_out, exp_q.pop_front());
                    end
                end
            end
            pv = word_valid; pr = word_ready; pa = abort; pw = word_out;
        end
    end

    // rmode: 0 random ready, 1 ready held high, 2 ready low for the first 5 valid cycles of a word.
    task automatic run(input bit rs, input int ln, input int rmode, input int abort_cyc,
                       input int restart_cyc);
        int c;
        int vcnt;
        int budget;
        bit fin;
        bit pend;
        bit hs;
        c = 0; vcnt = 0; fin = 1'b0; pend = 1'b0;
        budget = 60 + ln * (W + 1) * 4;
        v_cycs.delete(); hs_cycs.delete(); d_cycs.delete();
        busy0 = -1; busy1 = -1; busy_low = -1;
        start = 1'b1; reseed = rs; len = LENW'(ln); abort = (abort_cyc == 0);
        word_ready = (rmode == 1) ? 1'b1 : (rmode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        while (!fin && c < budget) begin
            @(negedge clk);
            hs = word_valid && word_ready && !abort;
            if (word_valid && !pend) v_cycs.push_back(c);
            if (word_valid) vcnt++;
            if (hs) begin
                hs_cycs.push_back(c);
                vcnt = 0;
            end
            pend = word_valid && !hs;
            if (done) d_cycs.push_back(c);
            if (c == 0) busy0 = int'(busy);
            if (c == 1) busy1 = int'(busy);
            if (c >= 1 && !busy) begin
                busy_low = c;
                fin      = 1'b1;
            end
            @(posedge clk);
            #1;
            c++;
            start = (c == restart_cyc);
            if (c == restart_cyc) len = LENW'(ln + 3);
            abort = (c == abort_cyc);
            case (rmode)
                0:       word_ready = 1'($urandom_range(0, 1));
                1:       word_ready = 1'b1;
                default: word_ready = (vcnt >= 5);
            endcase
        end
        start = 1'b0; abort = 1'b0; word_ready = 1'b0;
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL burst timeout: busy still high after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic check_burst(input string tag, input bit rs, input int ln);
        check({tag, " busy c0"}, busy0, 0);
        check({tag, " busy c1"}, busy1, 1);
        check({tag, " words"}, hs_cycs.size(), ln);
        check({tag, " done count"}, d_cycs.size(), 1);
        if (v_cycs.size() > 0) check({tag, " first valid"}, v_cycs[0], rs ? W + 2 : W + 1);
        if (hs_cycs.size() > 0 && d_cycs.size() > 0)
            check({tag, " done after last hs"}, d_cycs[0], hs_cycs[$] + 1);
        if (d_cycs.size() > 0) check({tag, " busy fall"}, busy_low, d_cycs[0] + 1);
        check({tag, " leftover"}, exp_q.size(), 0);
    endtask

    task automatic check_spacing(input string tag, input bit rs);
        for (int k = 0; k < v_cycs.size(); k++)
            check({tag, " valid cycle"}, v_cycs[k], (rs ? W + 2 : W + 1) + k * (W + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1; start = 1'b0; reseed = 1'b0; len = '0; abort = 1'b0; word_ready = 1'b0;
        g_state = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset valid", word_valid, 0);
        check("reset word", word_out, 0);
        check("reset done", done, 0);
        check("reset enable", dut.lfsr_I.enable, 0);
        check("reset clear", dut.lfsr_I.clear, 0);
        res = 1'b0;
        @(posedge clk);
        #1;

        // Reseeded two-word burst with ready held high.
        g_state = 0;
        push_words(2);
        run(1'b1, 2, 1, -1, -1);
        check_burst("main", 1'b1, 2);
        check_spacing("main", 1'b1);
        check("main valid count", v_cycs.size(), 2);
        if (d_cycs.size() > 0) check("main done cycle", d_cycs[0], 20);
        check("main busy low cycle", busy_low, 21);

        // Backpressure on a single word, then a continuation burst.
        push_words(1);
        run(1'b0, 1, 2, -1, -1);
        check_burst("hold", 1'b0, 1);
        if (hs_cycs.size() > 0) check("hold accept cycle", hs_cycs[0], W + 1 + 5);
        push_words(2);
        run(1'b0, 2, 1, -1, -1);
        check_burst("cont", 1'b0, 2);
        check_spacing("cont", 1'b0);

        // Zero-length burst leaves the stream untouched.
        run(1'b0, 0, 1, -1, -1);
        check("len0 done count", d_cycs.size(), 1);
        if (d_cycs.size() > 0) check("len0 done cycle", d_cycs[0], 1);
        check("len0 no valid", v_cycs.size(), 0);
        check("len0 busy low", busy_low, 2);
        push_words(1);
        run(1'b0, 1, 1, -1, -1);
        check_burst("after len0", 1'b0, 1);

        // Abort in the 4th FILL cycle: four bits consumed, no words, no done.
        for (int i = 0; i < 4; i++) void'(g_bit());
        run(1'b0, 3, 1, 4, -1);
        check("abort no done", d_cycs.size(), 0);
        check("abort no valid", v_cycs.size(), 0);
        check("abort busy low", busy_low, 5);
        push_words(1);
        run(1'b0, 1, 1, -1, -1);
        check_burst("after abort", 1'b0, 1);

        // Start while busy is ignored.
        push_words(2);
        run(1'b0, 2, 1, -1, 6);
        check_burst("restart", 1'b0, 2);

        // Start with abort together: nothing happens, no clear.
        run(1'b1, 3, 1, 0, -1);
        check("start+abort busy c1", busy1, 0);
        check("start+abort no done", d_cycs.size(), 0);
        check("start+abort no valid", v_cycs.size(), 0);
        push_words(1);
        run(1'b0, 1, 1, -1, -1);
        check_burst("after start+abort", 1'b0, 1);

        // Asynchronous reset during FILL, then a reseeded burst restarts the stream.
        start = 1'b1; reseed = 1'b1; len = LENW'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre-reset valid", word_valid, 0);
        check("pre-reset busy", busy, 1);
        res = 1'b1;
        #1;
        check("async reset busy", busy, 0);
        check("async reset valid", word_valid, 0);
        check("async reset word", word_out, 0);
        check("async reset done", done, 0);
        @(posedge clk);
        #1;
        res = 1'b0;
        g_state = 0;
        push_words(2);
        run(1'b1, 2, 1, -1, -1);
        check_burst("after reset", 1'b1, 2);

        // Randomized bursts with random backpressure.
        for (int it = 0; it < 8; it++) begin
            bit rs;
            int ln;
            rs = 1'($urandom_range(0, 1));
            ln = $urandom_range(1, 6);
            if (rs) g_state = 0;
            push_words(ln);
            run(rs, ln, 0, -1, -1);
            check_burst("random", rs, ln);
        end

        // Maximum length burst.
        push_words(255);
        run(1'b0, 255, 1, -1, -1);
        check_burst("maxlen", 1'b0, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
